// File: rtl/mvu_agu_ctrl_pkg.sv
// Shared widths, configuration bundle and FSM state type for the MVU address generator.
// Optional stall counter is enabled by defining MVU_AGU_PERFCNT_EN.
package mvu_agu_ctrl_pkg;

  localparam int BADDR   = 15;
  localparam int BJUMP   = 15;
  localparam int BLENGTH = 15;
  localparam int BCNTDWN = 29;
  localparam int NJUMPS  = 5;
  localparam int NLOOPS  = NJUMPS - 1;
  localparam int BSEL    = $clog2(NJUMPS);

  typedef struct packed {
    logic [BADDR-1:0]                 base;
    logic [NJUMPS-1:0][BJUMP-1:0]     jump;
    logic [NLOOPS-1:0][BLENGTH-1:0]   length;
    logic [BCNTDWN-1:0]               countdown;
  } agu_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } agu_state_e;

endpackage

// File: rtl/mvu_agu_ctrl_if.sv
// Address stream toward the bank read port: registered address with valid/ready.
interface mvu_agu_ctrl_if;
  import mvu_agu_ctrl_pkg::*;

  logic [BADDR-1:0] addr;
  logic             addr_valid;
  logic             addr_ready;

  modport master (output addr, output addr_valid, input addr_ready);
  modport slave  (input addr, input addr_valid, output addr_ready);

endinterface

// File: rtl/mvu_agu_ctrl_loopcnt.sv
// Loop-counter cascade: picks the jump level for the next step and reloads/decrements counters.
module mvu_agu_ctrl_loopcnt
  import mvu_agu_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_i,
  input  logic                           beat_i,
  input  logic [NLOOPS-1:0][BLENGTH-1:0] len_i,
  output logic [BSEL-1:0]                sel_o
);

  logic [NLOOPS-1:0][BLENGTH-1:0] len_q;
  logic [NLOOPS-1:0][BLENGTH-1:0] cnt_q;

  // Innermost non-exhausted level wins; all exhausted selects the outermost jump.
  always_comb begin
    sel_o = BSEL'(NLOOPS);
    for (int k = NLOOPS - 1; k >= 0; k--) begin
      if (cnt_q[k] != '0) sel_o = BSEL'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      len_q <= len_i;
      cnt_q <= len_i;
    end else if (beat_i) begin
      for (int k = 0; k < NLOOPS; k++) begin
        if (BSEL'(k) < sel_o)       cnt_q[k] <= len_q[k];
        else if (BSEL'(k) == sel_o) cnt_q[k] <= cnt_q[k] - BLENGTH'(1);
      end
    end
  end

endmodule

// File: rtl/mvu_agu_ctrl.sv
// Nested-loop address generator/sequencer for one MVU bank read port.
// Define MVU_AGU_PERFCNT_EN to build the saturating stall counter.
module mvu_agu_ctrl
  import mvu_agu_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [BADDR-1:0]               cfg_base_i,
  input  logic [NJUMPS-1:0][BJUMP-1:0]   cfg_jump_i,
  input  logic [NLOOPS-1:0][BLENGTH-1:0] cfg_length_i,
  input  logic [BCNTDWN-1:0]             cfg_countdown_i,
  mvu_agu_ctrl_if.master                 addr_if,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [31:0]                    stall_cnt_o
);

  agu_cfg_t                     cfg_w;
  agu_state_e                   state_q;
  logic [BADDR-1:0]             addr_q;
  logic                         valid_q;
  logic                         busy_q;
  logic                         done_q;
  logic [BCNTDWN-1:0]           cnt_q;
  logic [NJUMPS-1:0][BJUMP-1:0] jump_q;
  logic [BSEL-1:0]              sel;
  logic [BADDR-1:0]             jump_ext;
  logic                         beat;
  logic                         accept;
  logic                         adv;

  assign cfg_w.base      = cfg_base_i;
  assign cfg_w.jump      = cfg_jump_i;
  assign cfg_w.length    = cfg_length_i;
  assign cfg_w.countdown = cfg_countdown_i;

  assign beat     = valid_q & addr_if.addr_ready;
  assign accept   = (state_q == IDLE) & start_i & ~abort_i;
  // The last beat finishes the job, so it does not advance the loop state.
  assign adv      = beat & ~abort_i & (cnt_q != BCNTDWN'(1));
  assign jump_ext = BADDR'($signed(jump_q[sel]));

  mvu_agu_ctrl_loopcnt u_loopcnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .beat_i (adv),
    .len_i  (cfg_w.length),
    .sel_o  (sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      jump_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              jump_q <= cfg_w.jump;
              if (cfg_w.countdown != '0) begin
                state_q <= RUN;
                addr_q  <= cfg_w.base;
                cnt_q   <= cfg_w.countdown;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (beat) begin
              cnt_q <= cnt_q - BCNTDWN'(1);
              if (cnt_q == BCNTDWN'(1)) begin
                state_q <= DONE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                addr_q <= addr_q + jump_ext;
              end
            end
          end
          DONE: state_q <= IDLE;
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign addr_if.addr       = addr_q;
  assign addr_if.addr_valid = valid_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

`ifdef MVU_AGU_PERFCNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (valid_q && !addr_if.addr_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mvu_agu_ctrl.sv
// Scoreboard bench for mvu_agu_ctrl: expected addresses queued at start, popped on each beat.
module tb_mvu_agu_ctrl;
  import mvu_agu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic [BADDR-1:0]               base;
  logic [NJUMPS-1:0][BJUMP-1:0]   jmp;
  logic [NLOOPS-1:0][BLENGTH-1:0] len;
  logic [BCNTDWN-1:0]             cd;
  logic        busy;
  logic        done;
  logic [31:0] stall_cnt;

  mvu_agu_ctrl_if agu_if ();

  mvu_agu_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .abort_i         (abort),
    .cfg_base_i      (base),
    .cfg_jump_i      (jmp),
    .cfg_length_i    (len),
    .cfg_countdown_i (cd),
    .addr_if         (agu_if),
    .busy_o          (busy),
    .done_o          (done),
    .stall_cnt_o     (stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BADDR-1:0] exp_q[$];
  int ncyc = 0, done_cnt = 0, beat_cnt = 0, valid_seen = 0, stall_seen = 0;
  int last_beat_neg = 0, done_neg = 0;
  int d0, b0, v0;
  logic prev_stall = 1'b0;
  logic [BADDR-1:0] prev_addr = '0;
  bit bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int bp_ph = 0;

  task automatic chk(string tag, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (agu_if.addr_valid) valid_seen++;
      if (prev_stall) begin
        chk("hold_valid", agu_if.addr_valid, 1);
        chk("hold_addr", agu_if.addr, prev_addr);
      end
      if (agu_if.addr_valid && agu_if.addr_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("addr", agu_if.addr, exp_q.pop_front());
        beat_cnt++;
        last_beat_neg = ncyc;
      end
      if (agu_if.addr_valid && !agu_if.addr_ready) stall_seen++;
      if (done) begin
        done_cnt++;
        done_neg = ncyc;
      end
      prev_stall = agu_if.addr_valid && !agu_if.addr_ready;
      prev_addr  = agu_if.addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_mode) begin
      agu_if.addr_ready = bp_pat[bp_ph];
      bp_ph = (bp_ph + 1) % 4;
    end else begin
      agu_if.addr_ready = 1'b1;
    end
  endtask

  task automatic set_cfg1();
    base = 15'd100;
    jmp  = '0;
    jmp[0] = 15'd1;
    jmp[4] = 15'd10;
    len  = '0;
    len[0] = 15'd2;
    cd   = 29'd7;
  endtask

  task automatic push_cfg1();
    int seq[7] = '{100, 101, 102, 112, 113, 114, 124};
    foreach (seq[i]) exp_q.push_back(BADDR'(seq[i]));
  endtask

  // Reference walk of the nested loops for the current cfg inputs.
  task automatic model_push(int n);
    int a, j;
    int c[NLOOPS];
    a = int'(base);
    for (int k = 0; k < NLOOPS; k++) c[k] = int'(len[k]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(BADDR'(a));
      j = NLOOPS;
      for (int k = NLOOPS - 1; k >= 0; k--) if (c[k] != 0) j = k;
      a = (a + int'($signed(jmp[j]))) & ((1 << BADDR) - 1);
      for (int k = 0; k < j; k++) c[k] = int'(len[k]);
      if (j < NLOOPS) c[j] = c[j] - 1;
    end
  endtask

  task automatic start_job();
    d0 = done_cnt;
    b0 = beat_cnt;
    v0 = valid_seen;
    stall_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_job(string tag, int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, n < budget, 1);
    chk({tag, "_done_lat"}, done_neg, last_beat_neg + 1);
    chk({tag, "_leftover"}, exp_q.size(), 0);
    repeat (3) step();
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_busy_idle"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base = '0;
    jmp = '0;
    len = '0;
    cd = '0;
    agu_if.addr_ready = 1'b1;
    step();
    step();
    chk("rst_addr", agu_if.addr, 0);
    chk("rst_valid", agu_if.addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b0;
    step();

    // basic cascade
    set_cfg1();
    push_cfg1();
    start_job();
    chk("t1_first_valid", agu_if.addr_valid, 1);
    chk("t1_first_busy", busy, 1);
    chk("t1_first_addr", agu_if.addr, 100);
    finish_job("t1", 50);

    // wrap and negative jump
    base = 15'd5;
    jmp = '0;
    jmp[0] = 15'h7FFD;
    jmp[4] = 15'h7FFD;
    len = '0;
    cd = 29'd3;
    exp_q.push_back(15'd5);
    exp_q.push_back(15'd2);
    exp_q.push_back(15'd32767);
    start_job();
    finish_job("t2", 50);

    // backpressure
    set_cfg1();
    push_cfg1();
    bp_mode = 1'b1;
    bp_ph = 0;
    start_job();
    finish_job("t3", 100);
    chk("t3_stalls_seen", stall_seen > 0, 1);
`ifdef MVU_AGU_PERFCNT_EN
    chk("t3_stall_cnt", stall_cnt, stall_seen);
`else
    chk("t3_stall_cnt_off", stall_cnt, 0);
`endif
    bp_mode = 1'b0;
    step();

    // zero countdown
    cd = '0;
    start_job();
    chk("t4_done", done, 1);
    chk("t4_valid", agu_if.addr_valid, 0);
    step();
    chk("t4_done_clear", done, 0);
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_no_valid", valid_seen - v0, 0);

    // abort after 3 beats, then fresh start
    begin
      int n = 0;
      set_cfg1();
      push_cfg1();
      start_job();
      while (beat_cnt - b0 < 3 && n < 50) begin
        step();
        n++;
      end
      chk("t5_wait", n < 50, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t5_abort_valid", agu_if.addr_valid, 0);
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_done", done, 0);
      exp_q.delete();
      repeat (3) step();
      chk("t5_no_done", done_cnt - d0, 0);
      push_cfg1();
      start_job();
      chk("t5_restart_addr", agu_if.addr, 100);
      finish_job("t5r", 50);
    end

    // start during RUN with different config is ignored
    set_cfg1();
    push_cfg1();
    start_job();
    step();
    step();
    base = 15'd7000;
    jmp = '1;
    len = '1;
    cd = 29'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    finish_job("t6", 50);

    // reset mid-RUN
    set_cfg1();
    push_cfg1();
    start_job();
    repeat (3) step();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("t7_addr", agu_if.addr, 0);
    chk("t7_valid", agu_if.addr_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_stall", stall_cnt, 0);
    exp_q.delete();
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_idle_valid", agu_if.addr_valid, 0);

    // randomised jobs under backpressure
    for (int r = 0; r < 3; r++) begin
      base = BADDR'($urandom);
      for (int k = 0; k < NJUMPS; k++) jmp[k] = BJUMP'($urandom);
      for (int k = 0; k < NLOOPS; k++) len[k] = BLENGTH'($urandom_range(0, 3));
      cd = BCNTDWN'($urandom_range(20, 40));
      model_push(int'(cd));
      bp_mode = (r != 0);
      bp_ph = 0;
      start_job();
      finish_job("trand", 200);
      bp_mode = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
